// File: rtl/mul_add_seq.sv
//------------------------------------------------------------------------------
// mul_add_seq : sequential shift-and-add multiply-accumulate, result = a*b + c
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Maximum sum is 2^W*(2^W-1), so the 2W-bit accumulator never wraps.
    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_acc    <= {{WIDTH{1'b0}}, c};
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_cnt    <= '0;
                        r_state  <= CALC;
                        busy     <= 1'b1;
                    end else begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= w_acc_next;
                        overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_add_seq.sv
//------------------------------------------------------------------------------
// tb_mul_add_seq : directed and random checks of mul_add_seq against a model
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_add_seq;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               overflow;

    int tests = 0;
    int fails = 0;

    mul_add_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request accepted while not busy completes WIDTH edges later.
    int m_left   = 0;
    int m_pend   = 0;
    int m_result = 0;
    bit m_done   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   = 0;
            m_pend   = 0;
            m_result = 0;
            m_done   = 0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (start) begin
                    m_left = WIDTH;
                    m_pend = int'(a) * int'(b) + int'(c);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done   = 1;
                    m_result = m_pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy",     int'(busy),     int'(m_left != 0));
            chk("done",     int'(done),     int'(m_done));
            chk("result",   int'(result),   m_result);
            chk("overflow", int'(overflow), int'((m_result >> WIDTH) != 0));
            if (busy && done) chk("busy_and_done", 1, 0);
        end
    end

    // Waits for done; returns the number of negedges seen (0 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input int ia, input int ib, input int ic,
                         input int lit_res, input int lit_ovf, input string tag);
        int n;
        @(posedge clk); #2;
        start = 1'b1;
        a = ia[WIDTH-1:0]; b = ib[WIDTH-1:0]; c = ic[WIDTH-1:0];
        @(posedge clk); #2;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); c = WIDTH'($urandom);
        wait_done(n);
        if (n != 0) begin
            chk({tag, "_latency"}, n, WIDTH + 1);
            chk({tag, "_result"},  int'(result),   lit_res);
            chk({tag, "_ovf"},     int'(overflow), lit_ovf);
            chk({tag, "_model"},   m_result,       lit_res);
        end
    endtask

    initial begin
        int n, ra, rb, rc, exp;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;

        do_op(3, 3, 1, 10, 0, "t1");
        do_op(1, 4, 3, 7, 0, "t2a");
        do_op(0, 0, 9, 9, 0, "t2b");
        do_op(15, 15, 15, 240, 1, "t3");

        // Back-to-back: start held through DONE with new operands.
        @(posedge clk); #2;
        start = 1'b1; a = 4'd7; b = 4'd2; c = 4'd1;
        @(posedge clk); #2;
        a = 4'd2; b = 4'd5; c = 4'd0;
        wait_done(n);
        chk("t4_first", int'(result), 15);
        @(negedge clk);
        chk("t4_no_idle_busy", int'(busy), 1);
        #1 start = 1'b0;
        a = 4'd9; b = 4'd9; c = 4'd9;
        wait_done(n);
        chk("t4_second", int'(result), 10);
        chk("t4_second_latency", n, WIDTH);

        // Start pulses during CALC are ignored.
        @(posedge clk); #2;
        start = 1'b1; a = 4'd6; b = 4'd3; c = 4'd2;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        start = 1'b1; a = 4'd1; b = 4'd1; c = 4'd1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(n);
        chk("t4_ignored", int'(result), 20);
        repeat (2) @(posedge clk);

        // Asynchronous reset two cycles into CALC.
        @(posedge clk); #2;
        start = 1'b1; a = 4'd5; b = 4'd5; c = 4'd5;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_result", int'(result), 0);
        chk("t5_ovf", int'(overflow), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) chk("t5_spurious_done", 1, 0);
        end
        do_op(4, 3, 2, 14, 0, "t5_after");

        // Random operands, cross-checked by division.
        for (int k = 0; k < 200; k++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rc = int'($urandom_range(0, 15));
            exp = ra * rb + rc;
            do_op(ra, rb, rc, exp, int'(exp > 15), "rand");
            if (rb != 0 && rc < rb) begin
                chk("div_q", int'(result) / rb, ra);
                chk("div_r", int'(result) % rb, rc);
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
